// File: rtl/roulette_pkg.sv
// Shared types and constants for the roulette round controller.
// The optional restart-on-press behaviour is selected with ROULETTE_AUTO_RESTART_EN.
package roulette_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPIN,
      RESOLVE,
      PAYOUT,
      WON,
      LOST
   } state_t;

   localparam logic [4:0] LED_IDLE    = 5'b00001;
   localparam logic [4:0] LED_SPIN    = 5'b00010;
   localparam logic [4:0] LED_RESOLVE = 5'b00100;
   localparam logic [4:0] LED_PAYOUT  = 5'b01000;
   localparam logic [4:0] LED_WON     = 5'b11111;
   localparam logic [4:0] LED_LOST    = 5'b10101;

   localparam logic BET_NUM    = 1'b0;
   localparam logic BET_PARITY = 1'b1;

   localparam logic [4:0] LFSR_SEED = 5'b00001;
   // Feedback taps for x^5 + x^3 + 1 on a left-shifting register
   localparam logic [4:0] LFSR_TAPS = 5'b10100;

   function automatic logic [4:0] lfsr_next(input logic [4:0] cur);
      return {cur[3:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/roulette_lfsr.sv
// Free-running 5-bit maximal-length LFSR producing the wheel number 1..31.
module roulette_lfsr
   import roulette_pkg::*;
(
   input  logic       Clock,
   input  logic       reset_n,
   output logic [4:0] value
);

   logic [4:0] value_reg;

   always_ff @(posedge Clock) begin
      if (!reset_n) begin
         value_reg <= LFSR_SEED;
      end else begin
         value_reg <= lfsr_next(value_reg);
      end
   end

   assign value = value_reg;

endmodule

// File: rtl/roulette_round_ctrl.sv
// Roulette bet-round sequencer: spin, resolve, payout and bankroll tracking.
// Define ROULETTE_AUTO_RESTART_EN to let a press in WON/LOST restart the game.
module roulette_round_ctrl
   import roulette_pkg::*;
#(
   parameter int START_BAL   = 10,
   parameter int WIN_BAL     = 20,
   parameter int NUM_PAYOUT  = 4,
   parameter int PAR_PAYOUT  = 1,
   parameter int LOSS        = 1,
   parameter int SPIN_CYCLES = 16
) (
   input  logic       Clock,
   input  logic       reset_n,
   input  logic       spin_n,
   input  logic       bet_type,
   input  logic [4:0] playerGuess,
   output logic [4:0] playerBalance,
   output logic [4:0] result,
   output logic       spinning,
   output logic       round_win,
   output logic [1:0] game_over,
   output logic [4:0] fsm_out
);

   localparam int CNT_W = $clog2(SPIN_CYCLES + 1);

   logic [4:0]       lfsr_value;
   logic             spin_meta_reg, spin_sync_reg, spin_prev_reg;
   logic             press;
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [4:0]       balance_reg, result_reg, fsm_reg;
   logic             spinning_reg, win_reg, bet_reg;
   logic [1:0]       over_reg;
   logic [5:0]       pay_sum;

   roulette_lfsr u_lfsr (
      .Clock   (Clock),
      .reset_n (reset_n),
      .value   (lfsr_value)
   );

   // Button is asynchronous: two-flop synchronizer plus a copy for edge detect
   always_ff @(posedge Clock) begin
      if (!reset_n) begin
         spin_meta_reg <= 1'b1;
         spin_sync_reg <= 1'b1;
         spin_prev_reg <= 1'b1;
      end else begin
         spin_meta_reg <= spin_n;
         spin_sync_reg <= spin_meta_reg;
         spin_prev_reg <= spin_sync_reg;
      end
   end

   assign press = spin_prev_reg & ~spin_sync_reg;

   always_comb begin
      pay_sum = {1'b0, balance_reg};
      if (win_reg) begin
         pay_sum = pay_sum + ((bet_reg == BET_NUM) ? 6'(NUM_PAYOUT) : 6'(PAR_PAYOUT));
      end else begin
         pay_sum = pay_sum - 6'(LOSS);
      end
   end

   always_ff @(posedge Clock) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         balance_reg  <= 5'(START_BAL);
         result_reg   <= '0;
         win_reg      <= 1'b0;
         bet_reg      <= BET_NUM;
         over_reg     <= 2'b00;
         spinning_reg <= 1'b0;
         fsm_reg      <= LED_IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (press) begin
                  state_reg    <= SPIN;
                  cnt_reg      <= '0;
                  win_reg      <= 1'b0;
                  spinning_reg <= 1'b1;
                  fsm_reg      <= LED_SPIN;
               end
            end
            SPIN: begin
               if (cnt_reg == CNT_W'(SPIN_CYCLES - 1)) begin
                  state_reg    <= RESOLVE;
                  spinning_reg <= 1'b0;
                  fsm_reg      <= LED_RESOLVE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RESOLVE: begin
               result_reg <= lfsr_value;
               bet_reg    <= bet_type;
               win_reg    <= (bet_type == BET_NUM) ? (playerGuess == lfsr_value)
                                                   : (playerGuess[0] == lfsr_value[0]);
               state_reg  <= PAYOUT;
               fsm_reg    <= LED_PAYOUT;
            end
            PAYOUT: begin
               // Sign bit catches an underflow below zero as a loss
               if ($signed(pay_sum) <= 0) begin
                  balance_reg <= '0;
                  over_reg    <= 2'b10;
                  state_reg   <= LOST;
                  fsm_reg     <= LED_LOST;
               end else if (pay_sum >= 6'(WIN_BAL)) begin
                  balance_reg <= (pay_sum > 6'd31) ? 5'd31 : pay_sum[4:0];
                  over_reg    <= 2'b01;
                  state_reg   <= WON;
                  fsm_reg     <= LED_WON;
               end else begin
                  balance_reg <= pay_sum[4:0];
                  state_reg   <= IDLE;
                  fsm_reg     <= LED_IDLE;
               end
            end
            WON, LOST: begin
`ifdef ROULETTE_AUTO_RESTART_EN
               if (press) begin
                  balance_reg <= 5'(START_BAL);
                  result_reg  <= '0;
                  win_reg     <= 1'b0;
                  over_reg    <= 2'b00;
                  state_reg   <= IDLE;
                  fsm_reg     <= LED_IDLE;
               end
`else
               state_reg <= state_reg;
`endif
            end
            default: begin
               state_reg <= IDLE;
               fsm_reg   <= LED_IDLE;
            end
         endcase
      end
   end

   assign playerBalance = balance_reg;
   assign result        = spinning_reg ? lfsr_value : result_reg;
   assign spinning      = spinning_reg;
   assign round_win     = win_reg;
   assign game_over     = over_reg;
   assign fsm_out       = fsm_reg;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Randomized self-checking bench for roulette_round_ctrl against a bankroll/wheel model.
module tb_roulette_round_ctrl;

   localparam int SPIN = 16;

   logic       clk;
   logic       reset_n;
   logic       spin_n;
   logic       bet_type;
   logic [4:0] playerGuess;
   logic [4:0] playerBalance;
   logic [4:0] result;
   logic       spinning;
   logic       round_win;
   logic [1:0] game_over;
   logic [4:0] fsm_out;

   int compared = 0;
   int mismatched = 0;
   int k;          // wheel steps since the last reset
   int seq [31];   // wheel sequence starting from the seed
   int bal;
   int gover;

   roulette_round_ctrl #(.SPIN_CYCLES(SPIN)) dut (
      .Clock         (clk),
      .reset_n       (reset_n),
      .spin_n        (spin_n),
      .bet_type      (bet_type),
      .playerGuess   (playerGuess),
      .playerBalance (playerBalance),
      .result        (result),
      .spinning      (spinning),
      .round_win     (round_win),
      .game_over     (game_over),
      .fsm_out       (fsm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset_n) k <= 0;
      else          k <= k + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_led();
      if (gover == 1) return 31;
      if (gover == 2) return 21;
      return 1;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      bal = 10;
      gover = 0;
      tick();
   endtask

   // mode 0: clean press, 1: extra press mid-spin, 2: button held ~100 cycles
   task automatic do_round(input bit bt, input bit want_win, input int mode);
      int guard, nspin, pv, g;
      bit win;
      spin_n = 1'b0;
      guard = 0;
      while (spinning !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check("spin_start", spinning, 1);
      if (spinning !== 1'b1) begin
         spin_n = 1'b1;
         repeat (4) tick();
         return;
      end
      pv = seq[(k + SPIN) % 31];
      check("live_result", result, seq[k % 31]);
      if (bt == 1'b0) begin
         g = pv;
         if (!want_win) while (g == pv) g = $urandom_range(1, 31);
      end else begin
         g = ($urandom_range(0, 15) * 2) + (want_win ? (pv % 2) : 1 - (pv % 2));
      end
      playerGuess = 5'(g);
      bet_type = bt;
      if (mode != 2) spin_n = 1'b1;
      nspin = 0;
      while (spinning === 1'b1 && nspin < 100) begin
         if (mode == 1 && nspin == 5) spin_n = 1'b0;
         if (mode == 1 && nspin == 8) spin_n = 1'b1;
         tick();
         nspin++;
      end
      check("spin_len", nspin, SPIN);
      check("fsm_resolve", fsm_out, 5'b00100);
      tick();
      win = (bt == 1'b0) ? (g == pv) : ((g % 2) == (pv % 2));
      check("result", result, pv);
      check("round_win", round_win, win);
      check("fsm_payout", fsm_out, 5'b01000);
      bal = bal + (win ? (bt ? 1 : 4) : -1);
      if (bal >= 20) begin
         gover = 1;
         if (bal > 31) bal = 31;
      end else if (bal <= 0) begin
         gover = 2;
         bal = 0;
      end
      tick();
      check("balance", playerBalance, bal);
      check("game_over", game_over, gover);
      check("fsm_after", fsm_out, exp_led());
      if (mode != 0) begin
         nspin = 0;
         repeat (100) begin
            tick();
            if (spinning === 1'b1) nspin++;
         end
         check("no_extra_spin", nspin, 0);
         check("balance_hold", playerBalance, bal);
      end
      spin_n = 1'b1;
      repeat (4) tick();
   endtask

   task automatic press_game_over();
      spin_n = 1'b0;
      repeat (10) tick();
      spin_n = 1'b1;
      repeat (4) tick();
`ifdef ROULETTE_AUTO_RESTART_EN
      bal = 10;
      gover = 0;
      check("restart_result", result, 0);
`endif
      check("over_press_bal", playerBalance, bal);
      check("over_press_go", game_over, gover);
      check("over_press_fsm", fsm_out, exp_led());
      check("over_press_spin", spinning, 0);
   endtask

   initial begin
      int v;
      v = 1;
      for (int i = 0; i < 31; i++) begin
         seq[i] = v;
         v = ((v * 2) % 32) + (((v / 16) + (v / 4)) % 2);
      end
      spin_n = 1'b1;
      bet_type = 1'b0;
      playerGuess = 5'd1;
      reset_n = 1'b0;
      bal = 10;
      gover = 0;
      repeat (3) tick();
      check("rst_balance", playerBalance, 10);
      check("rst_result", result, 0);
      check("rst_win", round_win, 0);
      check("rst_game_over", game_over, 0);
      check("rst_fsm", fsm_out, 5'b00001);
      check("rst_spinning", spinning, 0);
      reset_n = 1'b1;
      repeat (4) tick();

      // exact win 10 -> 14
      do_round(1'b0, 1'b1, 0);

      // parity loss from a fresh bankroll, then lose down to zero
      do_reset();
      do_round(1'b1, 1'b0, 0);
      for (int i = 0; i < 8; i++) do_round(1'($urandom_range(0, 1)), 1'b0, 0);
      check("bal_at_one", playerBalance, 1);
      do_round(1'b1, 1'b0, 0);
      press_game_over();

      // 17 + number win -> 21 WON, with repeated and held presses on the way
      do_reset();
      do_round(1'b0, 1'b1, 0);
      do_round(1'b1, 1'b1, 1);
      do_round(1'b1, 1'b1, 2);
      do_round(1'b1, 1'b1, 0);
      do_round(1'b0, 1'b1, 0);
      press_game_over();

      // 16 + number win -> exactly 20
      do_reset();
      do_round(1'b0, 1'b1, 0);
      do_round(1'b1, 1'b1, 0);
      do_round(1'b1, 1'b1, 0);
      do_round(1'b0, 1'b1, 0);

      // 19 + parity win -> exactly 20
      do_reset();
      do_round(1'b0, 1'b1, 0);
      for (int i = 0; i < 6; i++) do_round(1'b1, 1'b1, 0);

      // reset in the fifth SPIN cycle aborts the round
      do_reset();
      do_round(1'b0, 1'b1, 0);
      spin_n = 1'b0;
      v = 0;
      while (spinning !== 1'b1 && v < 20) begin
         tick();
         v++;
      end
      repeat (4) tick();
      reset_n = 1'b0;
      tick();
      check("abort_fsm", fsm_out, 5'b00001);
      check("abort_balance", playerBalance, 10);
      check("abort_result", result, 0);
      check("abort_spinning", spinning, 0);
      reset_n = 1'b1;
      spin_n = 1'b1;
      bal = 10;
      gover = 0;
      repeat (4) tick();

      // randomized rounds, restarting whenever the game ends
      for (int i = 0; i < 40; i++) begin
         if (gover != 0) do_reset();
         do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/roulette_round_ctrl.md
Name: roulette_round_ctrl

Overview:
- Round sequencer for the roulette game: turns a player spin press into one complete bet round (spin → resolve → payout) and tracks the bankroll until the game is won or lost.
- Owns the 1..31 random source, replacing the 1..10 generator.
- Sits between the board KEY/SW inputs and the HEX/LED display drivers.
- Selected by the game-select mux alongside the blackjack controller.

Parameters:
- START_BAL, 10, bankroll loaded at reset/restart
- WIN_BAL, 20, bankroll at or above which the game is won
- NUM_PAYOUT, 4, credit for an exact-number win
- PAR_PAYOUT, 1, credit for an even/odd win
- LOSS, 1, debit for any losing bet
- SPIN_CYCLES, 16, clocks spent in SPIN (board build overrides to 25_000_000)

Ports:
- Clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- spin_n  in  1  active-low spin push button, asynchronous to Clock
- bet_type  in  1  0 = exact number, 1 = parity
- playerGuess  in  5  exact bet: number 1..31; parity bet: bit0 (0 = even, 1 = odd), bits 4:1 ignored
- playerBalance  out  5  current bankroll
- result  out  5  last resolved number; 0 before the first round
- spinning  out  1  high while in SPIN
- round_win  out  1  outcome of the last round; held until the next SPIN entry
- game_over  out  2  00 playing, 01 won, 10 lost
- fsm_out  out  5  LED pattern for the current state

Behaviour:
- Reset (reset_n low at a rising edge):
  - state = IDLE, playerBalance = START_BAL, result = 0, round_win = 0, game_over = 00, fsm_out = 00001.
  - Spin counter cleared; LFSR loaded with seed 5'b00001.
  - Reset mid-round aborts the round with no balance change.
- spin_n path:
  - Two-flop synchronizer, then a registered copy.
  - A press is a 1→0 transition of the synchronized value, giving a one-cycle pulse 3 clocks after the pin falls.
  - Presses are acted on only in IDLE. They are never queued. Holding the button gives one press.
- LFSR:
  - 5-bit Fibonacci, x^5+x^3+1, steps every clock in all states.
  - Sequence period 31, values 1..31, never 0.
- States and LED patterns:
  - IDLE (00001): wait for a press. On a press go to SPIN, clear the counter, set round_win = 0.
  - SPIN (00010): spinning = 1; result shows the live LFSR value. After exactly SPIN_CYCLES cycles go to RESOLVE.
  - RESOLVE (00100): one cycle. Latch result = LFSR and sample playerGuess/bet_type this cycle.
    - Exact bet wins when playerGuess == LFSR.
    - Parity bet wins when playerGuess[0] == LFSR[0].
    - round_win is set accordingly.
  - PAYOUT (01000): one cycle.
    - Compute a 6-bit sum: balance + NUM_PAYOUT/PAR_PAYOUT on a win, balance − LOSS on a loss.
    - Sum ≥ WIN_BAL → WON. playerBalance = min(sum, 31).
    - Sum ≤ 0 (signed) → LOST. playerBalance = 0.
    - Otherwise playerBalance = sum, back to IDLE.
  - WON (11111): game_over = 01; presses ignored.
  - LOST (10101): game_over = 10; presses ignored.
- Latency: press pulse to playerBalance update = SPIN_CYCLES + 2 clocks.
- Boundaries:
  - Balance 1 with a loss → 0 and LOST.
  - Balance 16 with a number win → 20 and WON (≥ is inclusive).
  - Balance 19 with a parity win → 20 and WON.
  - Reset has priority over every transition in the same cycle.

Optional Feature:
- Macro: ROULETTE_AUTO_RESTART_EN.
- Defined: a press in WON or LOST reloads START_BAL, clears result, round_win and game_over, and returns to IDLE. That press does not start a spin.
- Undefined: WON and LOST are exited only by reset_n.

Decomposition:
- Package roulette_pkg holds:
  - state encoding (3-bit enum IDLE, SPIN, RESOLVE, PAYOUT, WON, LOST)
  - fsm_out LED pattern constants
  - bet type constants BET_NUM / BET_PARITY
  - LFSR seed and tap constants
- Sub-module roulette_lfsr (Clock, reset_n, value[4:0]) is natural; the controller instantiates one.

Test Plan:
- Reset, then a press with bet_type = 0, playerGuess = LFSR value predicted by the bench model for the RESOLVE cycle → result matches, round_win = 1, playerBalance 10 → 14, state back to IDLE (fsm_out 00001) after SPIN_CYCLES + 2.
- Parity bet with playerGuess[0] ≠ predicted LFSR[0] → round_win = 0, playerBalance 10 → 9.
- Drive the bankroll to 1 (9 losing rounds), then one more losing round → playerBalance = 0, game_over = 10, fsm_out = 10101; further presses → no change.
- Bankroll 17 plus a number win → playerBalance = 21, game_over = 01, fsm_out = 11111.
- Second press during SPIN, and button held for 100 cycles → exactly one round, one balance update.
- Assert reset_n low in SPIN cycle 5 → next cycle IDLE, playerBalance = 10, result = 0, spinning = 0.
- With ROULETTE_AUTO_RESTART_EN, a press in LOST → IDLE, playerBalance = 10, game_over = 00.
